// File: rtl/bch_scoreboard.sv
// bch_scoreboard
//   Checks a BCH decoder's three result streams (errors-present flag, error
//   count and serialised error-locator vector) against the error pattern that
//   was injected into each frame. Expectations are pushed into a small queue
//   and each result stream consumes it through its own read pointer, so the
//   three streams may run at different latencies.
//
// Parameters
//   P      BCH parameter vector; B = data bits, ESZ = error-count width
//   BITS   error-locator beat width (must divide B)
//   DEPTH  expectation queue depth (power of two, >= 2)
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   push_i, push_error_i, ready_o  expectation enqueue; ready_o low when full
//   present_valid_i, present_i     decoder "errors present" result
//   count_valid_i, count_i         decoder error count
//   err_first_i/valid_i/last_i/i   error-locator beats, LSB-first
//   wrong_o, overflow_o, underflow_o   sticky failure / misuse flags
//   frames_checked_o, fail_count_o     data checks done, mismatch events (saturating)
//   cap_valid_o, cap_expected_o, cap_observed_o   first data-mismatch capture
//
// Configuration
//   Define BCH_SCOREBOARD_CAPTURE_EN to build the first-failure capture
//   registers; otherwise the cap_* outputs are tied to zero.

// Fallback parameter-vector helpers for builds without the BCH parameter header.
`ifndef BCH_SANE
`define BCH_SANE 32'h0010_0005
`endif
`ifndef BCH_DATA_BITS
`define BCH_DATA_BITS(P) (((P) >> 16) & 32'hffff)
`endif
`ifndef BCH_ERR_SZ
`define BCH_ERR_SZ(P) ((P) & 32'hffff)
`endif

module bch_scoreboard #(
    parameter logic [31:0] P     = `BCH_SANE,
    parameter int unsigned BITS  = 1,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned B    = `BCH_DATA_BITS(P),
    localparam int unsigned ESZ  = `BCH_ERR_SZ(P)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic [B-1:0]    push_error_i,
    output logic            ready_o,
    input  logic            present_valid_i,
    input  logic            present_i,
    input  logic            count_valid_i,
    input  logic [ESZ-1:0]  count_i,
    input  logic            err_first_i,
    input  logic            err_valid_i,
    input  logic            err_last_i,
    input  logic [BITS-1:0] err_i,
    output logic            wrong_o,
    output logic            overflow_o,
    output logic            underflow_o,
    output logic [31:0]     frames_checked_o,
    output logic [15:0]     fail_count_o,
    output logic            cap_valid_o,
    output logic [B-1:0]    cap_expected_o,
    output logic [B-1:0]    cap_observed_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t DepthPtr = ptr_t'(DEPTH);

    if ((B % BITS) != 0) begin : g_bad_bits
        $error("bch_scoreboard: BITS must divide the data width");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("bch_scoreboard: DEPTH must be a power of two and at least 2");
    end

    // Expectation storage: vector, its popcount and its OR-reduction
    logic [B-1:0]     mem_err_q [DEPTH];
    logic [ESZ-1:0]   mem_cnt_q [DEPTH];
    logic [DEPTH-1:0] mem_pres_q;

    ptr_t wr_q, rd_p_q, rd_c_q, rd_d_q;

    logic [B-1:0]  buf_q, buf_d;
    logic          chk_q, chk_d;
    logic          wrong_q, overflow_q, underflow_q;
    logic [31:0]   frames_q;
    logic [15:0]   fail_q, fail_d;

    // Queue status; the lagging pointer decides fullness
    logic full, push_ok, ovf_ev;
    logic emp_p, emp_c, emp_d;

    always_comb begin
        full = ((wr_q - rd_p_q) == DepthPtr) ||
               ((wr_q - rd_c_q) == DepthPtr) ||
               ((wr_q - rd_d_q) == DepthPtr);
    end

    assign push_ok = push_i & ~full;
    assign ovf_ev  = push_i & full;
    assign emp_p   = (rd_p_q == wr_q);
    assign emp_c   = (rd_c_q == wr_q);
    assign emp_d   = (rd_d_q == wr_q);

    // Check decode
    logic          pres_do, cnt_do, data_do;
    logic          pres_mis, cnt_mis, data_mis, misuse;
    logic [B-1:0]  exp_vec;
    logic [2:0]    ev_cnt;
    logic [16:0]   fail_sum;

    assign pres_do  = present_valid_i & ~emp_p;
    assign cnt_do   = count_valid_i & ~emp_c;
    assign data_do  = chk_q & ~emp_d;
    assign exp_vec  = mem_err_q[rd_d_q[AW-1:0]];
    assign pres_mis = pres_do & (present_i != mem_pres_q[rd_p_q[AW-1:0]]);
    assign cnt_mis  = cnt_do & (count_i != mem_cnt_q[rd_c_q[AW-1:0]]);
    assign data_mis = data_do & (buf_q != exp_vec);
    // Overflow and any underflows in one cycle count as a single misuse event
    assign misuse   = ovf_ev | (present_valid_i & emp_p) | (count_valid_i & emp_c) |
                      (chk_q & emp_d);

    always_comb begin
        ev_cnt   = 3'(pres_mis) + 3'(cnt_mis) + 3'(data_mis) + 3'(misuse);
        fail_sum = {1'b0, fail_q} + {14'd0, ev_cnt};
        fail_d   = fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
    end

    // Popcount of the pushed pattern, truncated to the error-count width
    logic [ESZ-1:0] pc;
    always_comb begin
        pc = '0;
        for (int i = 0; i < B; i++) begin
            pc = pc + ESZ'(push_error_i[i]);
        end
    end

    // Deserialiser: each beat enters at the top and older beats shift down,
    // so after the last beat the first beat sits in the LSBs.
    logic [B-1:0] beat;
    always_comb begin
        beat  = B'(err_i) << (B - BITS);
        buf_d = buf_q;
        chk_d = 1'b0;
        if (err_valid_i) begin
            buf_d = err_first_i ? beat : (beat | (buf_q >> BITS));
            chk_d = err_last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_err_q[wr_q[AW-1:0]]  <= push_error_i;
            mem_cnt_q[wr_q[AW-1:0]]  <= pc;
            mem_pres_q[wr_q[AW-1:0]] <= |push_error_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q        <= '0;
            rd_p_q      <= '0;
            rd_c_q      <= '0;
            rd_d_q      <= '0;
            buf_q       <= '0;
            chk_q       <= 1'b0;
            wrong_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            frames_q    <= '0;
            fail_q      <= '0;
        end else begin
            if (push_ok) wr_q   <= wr_q + ptr_t'(1);
            if (pres_do) rd_p_q <= rd_p_q + ptr_t'(1);
            if (cnt_do)  rd_c_q <= rd_c_q + ptr_t'(1);
            if (data_do) begin
                rd_d_q   <= rd_d_q + ptr_t'(1);
                frames_q <= frames_q + 32'd1;
            end
            buf_q       <= buf_d;
            chk_q       <= chk_d;
            fail_q      <= fail_d;
            wrong_q     <= wrong_q | (ev_cnt != 3'd0);
            overflow_q  <= overflow_q | ovf_ev;
            underflow_q <= underflow_q | (misuse & ~ovf_ev) |
                           (ovf_ev & ((present_valid_i & emp_p) | (count_valid_i & emp_c) |
                                      (chk_q & emp_d)));
        end
    end

    assign ready_o          = ~full;
    assign wrong_o          = wrong_q;
    assign overflow_o       = overflow_q;
    assign underflow_o      = underflow_q;
    assign frames_checked_o = frames_q;
    assign fail_count_o     = fail_q;

`ifdef BCH_SCOREBOARD_CAPTURE_EN
    logic         cap_valid_q;
    logic [B-1:0] cap_exp_q, cap_obs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid_q <= 1'b0;
            cap_exp_q   <= '0;
            cap_obs_q   <= '0;
        end else if (data_mis && !cap_valid_q) begin
            cap_valid_q <= 1'b1;
            cap_exp_q   <= exp_vec;
            cap_obs_q   <= buf_q;
        end
    end

    assign cap_valid_o    = cap_valid_q;
    assign cap_expected_o = cap_exp_q;
    assign cap_observed_o = cap_obs_q;
`else
    assign cap_valid_o    = 1'b0;
    assign cap_expected_o = '0;
    assign cap_observed_o = '0;
`endif

endmodule

// File: doc/bch_scoreboard.md
BCH_SCOREBOARD -- requirements
Module: bch_scoreboard

Interface
REQ-001 Parameter P, default `BCH_SANE: BCH parameter vector; B = `BCH_DATA_BITS(P), ESZ = `BCH_ERR_SZ(P).
REQ-002 Parameter BITS, default 1: error-locator beat width; B % BITS SHALL be 0, otherwise elaboration SHALL fail.
REQ-003 Parameter DEPTH, default 16: expectation queue depth; power of two, at least 2.
REQ-004 clk  input  1  clock; all logic SHALL be clocked on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 push  input  1  enqueue the expected error vector for one frame.
REQ-007 push_error  input  B  error pattern injected into that frame.
REQ-008 ready  output  1  queue not full.
REQ-009 present_valid / present_in  input  1 / 1  decoder "errors present" result.
REQ-010 count_valid / count_in  input  1 / ESZ  decoder error count.
REQ-011 err_first / err_valid / err_last  input  1 each  error-locator beat framing.
REQ-012 err  input  BITS  error-locator beat data; LSB-first frame order.
REQ-013 wrong  output  1  sticky failure flag.
REQ-014 overflow / underflow  output  1 / 1  sticky queue-misuse flags.
REQ-015 frames_checked  output  32  data comparisons completed.
REQ-016 fail_count  output  16  mismatch events.
REQ-017 cap_valid / cap_expected / cap_observed  output  1 / B / B  first-failure capture.

Function
REQ-018 On push with ready=1, the block SHALL store push_error, its popcount (ESZ bits) and its OR-reduction in slot wr, then advance wr.
REQ-019 Three independent read pointers SHALL exist: rd_p for presence, rd_c for count, rd_d for data; pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-020 ready SHALL be 0 when wr minus the oldest read pointer equals DEPTH.
REQ-021 A push with ready=0 SHALL be dropped and SHALL set overflow and wrong.
REQ-022 present_valid SHALL compare present_in against the presence bit at rd_p and advance rd_p; count_valid SHALL do the same with count_in against the popcount at rd_c, advancing rd_c.
REQ-023 Data deserialisation: a beat is accepted when err_valid=1. err_first loads buf = err << (B-BITS). Each later beat loads buf = (err << (B-BITS)) | (buf >> BITS). The frame completes on the beat carrying err_last.
REQ-024 One cycle after err_last, buf SHALL be compared against the vector at rd_d. In that cycle rd_d SHALL advance and frames_checked SHALL increment, wrapping at 2^32.
REQ-025 A check when its pointer equals wr SHALL set underflow and wrong; the pointer SHALL NOT advance, and for data checks frames_checked SHALL NOT increment.
REQ-026 An entry pushed in cycle n SHALL be checkable from cycle n+1; a push and a check in the same cycle on an empty queue is an underflow.
REQ-027 Any mismatch, overflow or underflow SHALL set wrong on the next edge; wrong SHALL clear only on reset.
REQ-028 fail_count SHALL add the number of events in a cycle (0-4: presence, count and data mismatch, plus overflow or underflow) and SHALL saturate at 16'hFFFF.
REQ-029 Push and all three checks SHALL be accepted in the same cycle without loss.

Reset
REQ-030 On reset, all pointers SHALL return to 0 (queue empty).
REQ-031 On reset, wrong, overflow, underflow, frames_checked, fail_count, cap_valid, cap_expected, cap_observed and buf SHALL be 0, and ready SHALL be 1 in the following cycle.
REQ-032 Reset SHALL take priority over push and over every check in the same cycle.
REQ-033 If reset is asserted mid-frame, the partially deserialised buf SHALL be discarded.

Configuration
REQ-034 With macro BCH_SCOREBOARD_CAPTURE_EN defined, the first data mismatch after reset SHALL latch expected into cap_expected and buf into cap_observed, and set cap_valid. Later mismatches SHALL NOT overwrite the capture.
REQ-035 Without BCH_SCOREBOARD_CAPTURE_EN, the cap_* ports SHALL remain present and driven constant 0, and no capture registers SHALL be inferred.

Verification
REQ-036 Test 1: DEPTH=4, BITS=1; push error=0; then present_in=0, count_in=0, B zero beats -> frames_checked=1, wrong=0, fail_count=0.
REQ-037 Test 2: push error with bits 0 and 3 set; count_in=2, present_in=1, matching beats -> no failure. Repeat with count_in=1 -> fail_count=1, wrong=1 next cycle.
REQ-038 Test 3: DEPTH=4; 4 pushes with no checks -> ready=0. A 5th push -> overflow=1, wrong=1, and the queue contents are unchanged.
REQ-039 Test 4: count_valid asserted on an empty queue -> underflow=1, rd_c unchanged, frames_checked unchanged.
REQ-040 Test 5: BITS=B/2; flip the last beat's MSB -> data mismatch. With BCH_SCOREBOARD_CAPTURE_EN, cap_observed differs from cap_expected in bit B-1, and a second mismatch leaves the capture unchanged.
REQ-041 Test 6: assert reset mid-frame with 3 entries queued -> all outputs zero and ready=1; a fresh push/check sequence then passes.
